// File: rtl/uart_rx_oversample.sv
// UART receiver driven by a 16x oversampling tick.
// Deserialises start + DBIT data bits (LSB first) + optional parity + stop
// period, then presents the word with a one-clk done strobe and error flags.
module uart_rx_oversample #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PARITY  = 0,
    parameter int CNT_W   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err,
    output logic            busy
);

    localparam int N_W = $clog2(DBIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] s, s_next;
    logic [N_W-1:0]   n, n_next;
    logic [DBIT-1:0]  b, b_next;
    logic             pbit, pbit_next;
    logic             done_next;
    logic             rx_meta, rx_s;
    logic             par_calc;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state, counters and shift register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            s     <= '0;
            n     <= '0;
            b     <= '0;
            pbit  <= 1'b0;
        end else begin
            state <= state_next;
            s     <= s_next;
            n     <= n_next;
            b     <= b_next;
            pbit  <= pbit_next;
        end
    end

    // Parity check on the finished word; odd parity expects an odd total count.
    assign par_calc = (PARITY == 1) ? ~(^b ^ pbit) :
                      (PARITY == 2) ?  (^b ^ pbit) : 1'b0;

    // Result registers: only rewritten on the completing STOP tick so they
    // hold across the next frame until its own strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout         <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            rx_done_tick <= done_next;
            if (done_next) begin
                dout       <= b;
                frame_err  <= ~rx_s;
                parity_err <= par_calc;
            end
        end
    end

    // Next-state logic; counters only move on s_tick.
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        pbit_next  = pbit;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == CNT_W'(7)) begin
                        // Still low at mid start bit: real start, otherwise a glitch.
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == CNT_W'(15)) begin
                        s_next = '0;
                        b_next = {rx_s, b[DBIT-1:1]};
                        if (n == N_W'(DBIT-1))
                            state_next = (PARITY != 0) ? PAR : STOP;
                        else
                            n_next = n + 1'b1;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            PAR: begin
                if (s_tick) begin
                    if (s == CNT_W'(15)) begin
                        s_next     = '0;
                        pbit_next  = rx_s;
                        state_next = STOP;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == CNT_W'(SB_TICK-1)) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        s_next = s + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: doc/uart_rx_oversample.md
Name: uart_rx_oversample

Overview:
UART serial receiver that consumes the 16x-oversampling baud tick from the team's mod-M baud counter. It deserialises one asynchronous frame: start bit, DBIT data bits LSB first, optional parity bit, and a stop period. Each completed frame is presented on a parallel output with a one-cycle done strobe and error flags. It sits between the board rx pin and the receive FIFO / command parser.

Parameters:
DBIT, 8, number of data bits per frame (legal 5..9)
SB_TICK, 16, s_tick count for the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2)
PARITY, 0, 0 = none, 1 = odd, 2 = even
CNT_W, 5, width of the oversample tick counter; must satisfy 2^CNT_W > SB_TICK-1

Ports:
clk  input  1  system clock; all logic is on its rising edge
reset  input  1  asynchronous, active-high reset
rx  input  1  raw serial line; idle high; asynchronous to clk
s_tick  input  1  one-clk pulse at 16x baud (max_tick of the baud counter)
dout  output  DBIT  last received data word
rx_done_tick  output  1  one-clk strobe: dout, frame_err and parity_err just updated
frame_err  output  1  stop bit sampled low on last frame
parity_err  output  1  parity mismatch on last frame (always 0 when PARITY=0)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, active-high): state=IDLE, tick counter s=0, bit counter n=0, shift register b=0, dout=0, rx_done_tick=0, frame_err=0, parity_err=0, busy=0. Both synchroniser flops reset to 1 (line idle).
- rx passes through a 2-flop synchroniser; the FSM sees only rx_s. This adds 2 clk of latency; no other filtering.
- s and n advance only in cycles where s_tick=1; a cycle with s_tick=0 holds all counters.
- IDLE: rx_s=0 -> START with s=0. This check is independent of s_tick.
- START: on s_tick with s==7 (mid start bit): if rx_s=0 -> DATA with s=0, n=0; if rx_s=1 -> IDLE as a glitch, with no strobe and no flag change. Otherwise s++.
- DATA: on s_tick with s==15: s=0, b={rx_s, b[DBIT-1:1]} (LSB first). If n==DBIT-1: go to PAR when PARITY!=0, else go to STOP. Otherwise n++. Otherwise s++.
- PAR: on s_tick with s==15: s=0, capture rx_s as pbit, go to STOP.
- STOP: on s_tick with s==SB_TICK-1, go to IDLE and, at the same clk edge:
  - dout<=b
  - frame_err<=~rx_s
  - parity_err<=(PARITY==1) ? ~(^b ^ pbit) : (PARITY==2) ? (^b ^ pbit) : 0
  - rx_done_tick<=1
  Otherwise s++.
- rx_done_tick is registered, high for exactly one clk, and deasserts on the next clk regardless of s_tick.
- dout, frame_err and parity_err hold their values until the next rx_done_tick; they are not cleared at frame start.
- A frame with frame_err=1 still updates dout and still strobes.
- A low line in STOP does not restart reception early. After returning to IDLE, a line that is still low (break condition) starts a new frame immediately, which yields repeated frames of 0 with frame_err=1.
- Back-to-back frames: IDLE->START takes 1 clk after rx_s falls, so a start bit immediately following the stop period is accepted.
- Reset mid-frame forces IDLE immediately; the partial frame is discarded and no strobe is produced.
- s_tick continuously high is legal; the FSM then runs at one tick per clk.

Test Plan:
1. PARITY=0, s_tick every 4 clk, send 0xA5 with 1 stop bit -> exactly one rx_done_tick, dout=0xA5, frame_err=0, parity_err=0, busy low afterwards.
2. rx low for 4 s_ticks then high (glitch) -> FSM returns to IDLE, no rx_done_tick, dout keeps previous 0xA5.
3. Send 0x3C with stop bit driven 0 -> rx_done_tick, dout=0x3C, frame_err=1. Next clean frame 0x55 -> frame_err=0.
4. PARITY=2 (even): send 0x07 with parity bit 1 -> parity_err=0. Send 0x07 with parity bit 0 -> parity_err=1.
5. Two back-to-back frames 0x12, 0x34 with no idle gap -> two strobes, dout=0x12 then 0x34, no errors.
6. Assert reset during data bit 4 of a frame, release, then send 0x81 -> no strobe for the aborted frame, dout=0x81 with one strobe.
